// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_pkg
// Brief    : Shared state encoding and constants for the program loader.
// Revision : 1.0
// ============================================================================
package prog_loader_pkg;

    localparam int c_hdr_bytes         = 4;
    localparam int c_mem_words_default = 256;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HDR_ADDR = 3'd1,
        S_HDR_CNT  = 3'd2,
        S_DATA     = 3'd3,
        S_WRITE    = 3'd4,
        S_LAUNCH   = 3'd5,
        S_DONE     = 3'd6,
        S_ERR      = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_if
// Brief    : Byte stream, instruction-memory and core-control bundle.
// Revision : 1.0
// ============================================================================
interface prog_loader_if;

    logic        i_load_req;
    logic        i_byte_valid;
    logic [7:0]  i_byte;
    logic        o_byte_ready;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_data;
    logic        o_core_stall;
    logic        o_pc_writing_first_addr;
    logic [31:0] o_pc_start_addr;
    logic        o_done;
    logic        o_err;

    modport master (
        output i_load_req, i_byte_valid, i_byte,
        input  o_byte_ready, o_mem_we, o_mem_addr, o_mem_data, o_core_stall,
               o_pc_writing_first_addr, o_pc_start_addr, o_done, o_err
    );

    modport slave (
        input  i_load_req, i_byte_valid, i_byte,
        output o_byte_ready, o_mem_we, o_mem_addr, o_mem_data, o_core_stall,
               o_pc_writing_first_addr, o_pc_start_addr, o_done, o_err
    );

endinterface
`default_nettype wire

// File: rtl/prog_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_packer
// Brief    : Shifts four accepted bytes into a little-endian 32-bit word.
// Revision : 1.0
// ============================================================================
module byte_packer
    import prog_loader_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_clear,
    input  wire logic        i_valid,
    input  wire logic [7:0]  i_byte,
    output logic      [31:0] o_word,
    output logic             o_full
);

    logic [1:0]  r_cnt;
    logic [23:0] r_word;

    // Only the three earlier bytes are stored; the fourth is merged on the fly
    // so the owner sees the complete word in the same cycle it is accepted.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_valid) begin
            r_cnt  <= r_cnt + 2'd1;
            r_word <= {i_byte, r_word[23:8]};
        end
    end

    assign o_word = {i_byte, r_word};
    assign o_full = i_valid && (r_cnt == 2'(c_hdr_bytes - 1));

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Brief    : Parses a header+payload byte stream into instruction memory and
//            launches the core at the programmed start address.
// Revision : 1.0
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int MEM_WORDS = c_mem_words_default
)(
    input  wire logic     clk,
    input  wire logic     rst,
    prog_loader_if.slave  bus
);

    localparam logic [32:0] c_mem_words = 33'(MEM_WORDS);

    state_t      r_state;
    logic [31:0] r_start_addr;
    logic [31:0] r_count;
    logic [31:0] r_idx;
    logic        r_byte_ready;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_data;
    logic        r_core_stall;
    logic        r_pc_we;
    logic [31:0] r_pc_start;
    logic        r_done;
    logic        r_err;

    logic        w_accept;
    logic        w_clear;
    logic        w_full;
    logic [31:0] w_word;
    logic [32:0] w_end_word;

    assign w_accept = r_byte_ready && bus.i_byte_valid;
    assign w_clear  = bus.i_load_req &&
                      (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    // Widened so a huge COUNT cannot wrap past the memory-depth check.
    assign w_end_word = {3'b000, r_start_addr[31:2]} + {1'b0, w_word};

    byte_packer u_packer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_valid (w_accept),
        .i_byte  (bus.i_byte),
        .o_word  (w_word),
        .o_full  (w_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_start_addr <= '0;
            r_count      <= '0;
            r_idx        <= '0;
            r_byte_ready <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_core_stall <= 1'b1;
            r_pc_we      <= 1'b0;
            r_pc_start   <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            r_pc_we  <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.i_load_req) begin
                        r_state      <= S_HDR_ADDR;
                        r_byte_ready <= 1'b1;
                        r_idx        <= '0;
                        r_done       <= 1'b0;
                        r_err        <= 1'b0;
                        r_core_stall <= 1'b1;
                    end
                end
                S_HDR_ADDR: begin
                    if (w_full) begin
                        r_start_addr <= w_word;
                        if (w_word[1:0] != 2'b00) begin
                            r_state      <= S_ERR;
                            r_err        <= 1'b1;
                            r_byte_ready <= 1'b0;
                        end else begin
                            r_state <= S_HDR_CNT;
                        end
                    end
                end
                S_HDR_CNT: begin
                    if (w_full) begin
                        r_count <= w_word;
                        if (w_word == 32'd0 || w_end_word > c_mem_words) begin
                            r_state      <= S_ERR;
                            r_err        <= 1'b1;
                            r_byte_ready <= 1'b0;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_full) begin
                        r_state      <= S_WRITE;
                        r_byte_ready <= 1'b0;
                        r_mem_we     <= 1'b1;
                        r_mem_addr   <= r_start_addr + {r_idx[29:0], 2'b00};
                        r_mem_data   <= w_word;
                    end
                end
                S_WRITE: begin
                    r_idx <= r_idx + 32'd1;
                    if (r_idx == r_count - 32'd1) begin
                        r_state    <= S_LAUNCH;
                        r_pc_we    <= 1'b1;
                        r_pc_start <= r_start_addr;
                    end else begin
                        r_state      <= S_DATA;
                        r_byte_ready <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    r_state      <= S_DONE;
                    r_done       <= 1'b1;
                    r_core_stall <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_byte_ready            = r_byte_ready;
    assign bus.o_mem_we                = r_mem_we;
    assign bus.o_mem_addr              = r_mem_addr;
    assign bus.o_mem_data              = r_mem_data;
    assign bus.o_core_stall            = r_core_stall;
    assign bus.o_pc_writing_first_addr = r_pc_we;
    assign bus.o_pc_start_addr         = r_pc_start;
    assign bus.o_done                  = r_done;
    assign bus.o_err                   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Brief    : Directed self-checking bench for prog_loader.
// Revision : 1.0
// ============================================================================
module tb_prog_loader;

    typedef logic [7:0] byte_q_t[$];

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    prog_loader_if ifc ();

    prog_loader #(.MEM_WORDS(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ifc.o_mem_we === 1'b1) begin
            wr_addr_q.push_back(ifc.o_mem_addr);
            wr_data_q.push_back(ifc.o_mem_data);
        end
    end

    // Presents one byte and returns at the negedge after it was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        ifc.i_byte_valid = 1'b1;
        ifc.i_byte       = b;
        while (ifc.o_byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (ifc.o_byte_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL byte_ready_timeout: byte %h not accepted in %0d cycles, want ready=1", b, n);
        end
        @(negedge clk);
        ifc.i_byte_valid = 1'b0;
    endtask

    task automatic send_stream(input byte_q_t s, input int max_gap);
        int g;
        foreach (s[i]) begin
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (g) @(negedge clk);
            send_byte(s[i]);
        end
    endtask

    task automatic start_load(input bit with_byte);
        ifc.i_load_req = 1'b1;
        if (with_byte) begin
            ifc.i_byte_valid = 1'b1;
            ifc.i_byte       = 8'hFF;
        end
        @(negedge clk);
        ifc.i_load_req   = 1'b0;
        ifc.i_byte_valid = 1'b0;
        tests_run++;
        if (ifc.o_byte_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_start_ready: got %b want 1", ifc.o_byte_ready);
        end
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (ifc.o_core_stall !== 1'b1 || ifc.o_byte_ready !== 1'b0 || ifc.o_mem_we !== 1'b0 ||
            ifc.o_done !== 1'b0 || ifc.o_err !== 1'b0 || ifc.o_pc_writing_first_addr !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: stall=%b ready=%b we=%b done=%b err=%b pcwe=%b want 1 0 0 0 0 0",
                     ifc.o_core_stall, ifc.o_byte_ready, ifc.o_mem_we, ifc.o_done, ifc.o_err,
                     ifc.o_pc_writing_first_addr);
        end
        tests_run++;
        if (ifc.o_mem_addr !== 32'd0 || ifc.o_mem_data !== 32'd0 || ifc.o_pc_start_addr !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_data: addr=%h data=%h pc=%h want all 0",
                     ifc.o_mem_addr, ifc.o_mem_data, ifc.o_pc_start_addr);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        byte_q_t     hdr;
        logic [7:0]  words [2][4];
        logic [31:0] exp_addr [2];
        logic [31:0] exp_data [2];
        hdr = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        words[0] = '{8'h13, 8'h00, 8'h00, 8'h00};
        words[1] = '{8'h93, 8'h00, 8'h10, 8'h00};
        exp_addr = '{32'h0000_0100, 32'h0000_0104};
        exp_data = '{32'h0000_0013, 32'h0010_0093};
        // A byte offered alongside the request must be ignored.
        start_load(1'b1);
        send_stream(hdr, 0);
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 4; k++) send_byte(words[w][k]);
            tests_run++;
            if (ifc.o_mem_we !== 1'b1 || ifc.o_mem_addr !== exp_addr[w] ||
                ifc.o_mem_data !== exp_data[w] || ifc.o_byte_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL basic_write%0d: we=%b addr=%h data=%h ready=%b want 1 %h %h 0",
                         w, ifc.o_mem_we, ifc.o_mem_addr, ifc.o_mem_data, ifc.o_byte_ready,
                         exp_addr[w], exp_data[w]);
            end
        end
        @(negedge clk);
        tests_run++;
        if (ifc.o_pc_writing_first_addr !== 1'b1 || ifc.o_pc_start_addr !== 32'h100 ||
            ifc.o_mem_we !== 1'b0 || ifc.o_core_stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_launch: pcwe=%b pc=%h we=%b stall=%b want 1 00000100 0 1",
                     ifc.o_pc_writing_first_addr, ifc.o_pc_start_addr, ifc.o_mem_we, ifc.o_core_stall);
        end
        @(negedge clk);
        tests_run++;
        if (ifc.o_done !== 1'b1 || ifc.o_core_stall !== 1'b0 ||
            ifc.o_pc_writing_first_addr !== 1'b0 || ifc.o_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_done: done=%b stall=%b pcwe=%b err=%b want 1 0 0 0",
                     ifc.o_done, ifc.o_core_stall, ifc.o_pc_writing_first_addr, ifc.o_err);
        end
        tests_run++;
        if (wr_addr_q.size() != 2) begin
            tests_failed++;
            $display("FAIL basic_write_count: got %0d want 2", wr_addr_q.size());
        end
    endtask

    task automatic test_header_err(input string name, input byte_q_t hdr);
        start_load(1'b0);
        send_stream(hdr, 0);
        tests_run++;
        if (ifc.o_err !== 1'b1 || ifc.o_core_stall !== 1'b1 || ifc.o_byte_ready !== 1'b0 ||
            ifc.o_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_err: err=%b stall=%b ready=%b done=%b want 1 1 0 0",
                     name, ifc.o_err, ifc.o_core_stall, ifc.o_byte_ready, ifc.o_done);
        end
        ifc.i_byte_valid = 1'b1;
        ifc.i_byte       = 8'h55;
        repeat (6) @(negedge clk);
        ifc.i_byte_valid = 1'b0;
        tests_run++;
        if (wr_addr_q.size() != 0 || ifc.o_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_nowrite: writes=%0d err=%b want 0 1", name, wr_addr_q.size(), ifc.o_err);
        end
    endtask

    task automatic test_single(input string name, input byte_q_t s, input int max_gap,
                               input logic [31:0] exp_addr, input logic [31:0] exp_data);
        start_load(1'b0);
        send_stream(s, max_gap);
        repeat (3) @(negedge clk);
        tests_run++;
        if (wr_addr_q.size() != 1 || ifc.o_done !== 1'b1 || ifc.o_pc_start_addr !== exp_addr) begin
            tests_failed++;
            $display("FAIL %s_done: writes=%0d done=%b pc=%h want 1 1 %h",
                     name, wr_addr_q.size(), ifc.o_done, ifc.o_pc_start_addr, exp_addr);
        end else begin
            tests_run++;
            if (wr_addr_q[0] !== exp_addr || wr_data_q[0] !== exp_data) begin
                tests_failed++;
                $display("FAIL %s_write: addr=%h data=%h want %h %h",
                         name, wr_addr_q[0], wr_data_q[0], exp_addr, exp_data);
            end
        end
    endtask

    task automatic test_gaps();
        byte_q_t s;
        logic [31:0] exp_addr [2];
        logic [31:0] exp_data [2];
        s = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
              8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        exp_addr = '{32'h0000_0100, 32'h0000_0104};
        exp_data = '{32'h0000_0013, 32'h0010_0093};
        start_load(1'b0);
        send_stream(s, 3);
        repeat (3) @(negedge clk);
        tests_run++;
        if (wr_addr_q.size() != 2 || ifc.o_done !== 1'b1 || ifc.o_pc_start_addr !== 32'h100) begin
            tests_failed++;
            $display("FAIL gaps_done: writes=%0d done=%b pc=%h want 2 1 00000100",
                     wr_addr_q.size(), ifc.o_done, ifc.o_pc_start_addr);
        end else begin
            for (int i = 0; i < 2; i++) begin
                tests_run++;
                if (wr_addr_q[i] !== exp_addr[i] || wr_data_q[i] !== exp_data[i]) begin
                    tests_failed++;
                    $display("FAIL gaps_write%0d: addr=%h data=%h want %h %h",
                             i, wr_addr_q[i], wr_data_q[i], exp_addr[i], exp_data[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        byte_q_t s;
        s = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
        start_load(1'b0);
        send_stream(s, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (ifc.o_core_stall !== 1'b1 || ifc.o_byte_ready !== 1'b0 || ifc.o_done !== 1'b0 ||
            ifc.o_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_idle: stall=%b ready=%b done=%b err=%b want 1 0 0 0",
                     ifc.o_core_stall, ifc.o_byte_ready, ifc.o_done, ifc.o_err);
        end
        s = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
              8'hEF, 8'hBE, 8'hAD, 8'hDE};
        test_single("midrst_reload", s, 0, 32'h0, 32'hDEAD_BEEF);
    endtask

    task automatic test_reload();
        byte_q_t s;
        ifc.i_load_req = 1'b1;
        @(negedge clk);
        ifc.i_load_req = 1'b0;
        tests_run++;
        if (ifc.o_done !== 1'b0 || ifc.o_core_stall !== 1'b1 || ifc.o_byte_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reload_clear: done=%b stall=%b ready=%b want 0 1 1",
                     ifc.o_done, ifc.o_core_stall, ifc.o_byte_ready);
        end
        wr_addr_q.delete();
        wr_data_q.delete();
        s = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
              8'h44, 8'h33, 8'h22, 8'h11};
        send_stream(s, 0);
        tests_run++;
        if (ifc.o_mem_we !== 1'b1 || ifc.o_mem_addr !== 32'h8 || ifc.o_mem_data !== 32'h1122_3344 ||
            ifc.o_core_stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL reload_write: we=%b addr=%h data=%h stall=%b want 1 00000008 11223344 1",
                     ifc.o_mem_we, ifc.o_mem_addr, ifc.o_mem_data, ifc.o_core_stall);
        end
        @(negedge clk);
        tests_run++;
        if (ifc.o_pc_writing_first_addr !== 1'b1 || ifc.o_pc_start_addr !== 32'h8 ||
            ifc.o_core_stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL reload_launch: pcwe=%b pc=%h stall=%b want 1 00000008 1",
                     ifc.o_pc_writing_first_addr, ifc.o_pc_start_addr, ifc.o_core_stall);
        end
        @(negedge clk);
        tests_run++;
        if (ifc.o_done !== 1'b1 || ifc.o_core_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL reload_done: done=%b stall=%b want 1 0", ifc.o_done, ifc.o_core_stall);
        end
    endtask

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        rst              = 1'b1;
        ifc.i_load_req   = 1'b0;
        ifc.i_byte_valid = 1'b0;
        ifc.i_byte       = 8'h00;
        test_reset();
        test_basic();
        test_header_err("misalign", '{8'h02, 8'h01, 8'h00, 8'h00});
        test_header_err("count0",   '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        test_header_err("overflow", '{8'hFC, 8'h03, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00});
        test_single("lastword", '{8'hFC, 8'h03, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                                  8'h78, 8'h56, 8'h34, 8'h12}, 0, 32'h3FC, 32'h1234_5678);
        test_gaps();
        test_reset_mid();
        test_reload();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
